// File: rtl/source_controller.sv
// Source-domain control stage of the AHB-to-AHB bridge: packs requests into the
// request FIFO, returns read responses with a watchdog, and runs the source sleep handshake.
module source_controller #(
  parameter int unsigned ADDR_WIDTH = 32,
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned TIMEOUT    = 1024,
  parameter int unsigned CNT_W      = 11
) (
  input  logic                             i_clk_source,
  input  logic                             i_rst_source,
  input  logic                             i_valid,
  input  logic                             i_rd0_wr1,
  input  logic [ADDR_WIDTH-1:0]            i_addr,
  input  logic [DATA_WIDTH-1:0]            i_wr_data,
  output logic                             o_ready,
  output logic                             o_rd_valid,
  output logic [DATA_WIDTH-1:0]            o_rd_data,
  output logic                             o_rd_err,
  input  logic                             req_fifo_full,
  input  logic                             req_fifo_empty,
  output logic                             req_fifo_wr_en,
  output logic [ADDR_WIDTH+DATA_WIDTH+1:0] o_packet,
  input  logic                             rsp_fifo_empty,
  input  logic [DATA_WIDTH:0]              i_rsp_packet,
  output logic                             rsp_fifo_rd_en,
  input  logic                             i_source_sleep_req,
  output logic                             o_source_sleep_ack,
  output logic                             source_sleep_status,
  input  logic                             sink_sleep_status,
  output logic                             reset_flag
);

  localparam int unsigned STALE_W = 2;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_WAIT_RSP,
    ST_DRAIN,
    ST_SLEEP
  } state_t;

  state_t               state_q, state_n;
  logic [CNT_W-1:0]     cnt_q, cnt_n;
  logic [STALE_W-1:0]   stale_q, stale_n;
  logic                 accept;
  logic                 discard;
  logic                 match;
  logic                 timeout;
  logic [DATA_WIDTH-1:0] pkt_data;

  // Reads carry no payload; the constant 1 marks a valid packet for the sink.
  assign pkt_data = i_rd0_wr1 ? i_wr_data : DATA_WIDTH'(0);
  assign o_packet = {i_rd0_wr1, 1'b1, i_addr, pkt_data};

  // Next-state, watchdog, stale bookkeeping and FIFO handshakes.
  always_comb begin
    state_n        = state_q;
    cnt_n          = '0;
    stale_n        = stale_q;
    o_ready        = 1'b0;
    accept         = 1'b0;
    match          = 1'b0;
    timeout        = 1'b0;
    req_fifo_wr_en = 1'b0;
    discard        = !rsp_fifo_empty && (stale_q != STALE_W'(0));
    rsp_fifo_rd_en = discard;

    unique case (state_q)
      ST_IDLE: begin
        o_ready        = !req_fifo_full && !i_source_sleep_req;
        accept         = i_valid && !req_fifo_full && !i_source_sleep_req;
        req_fifo_wr_en = accept;
        if (accept) begin
          if (!i_rd0_wr1) state_n = ST_WAIT_RSP;
        end else if (i_source_sleep_req) begin
          state_n = ST_DRAIN;
        end
      end
      ST_WAIT_RSP: begin
        cnt_n = cnt_q + CNT_W'(1);
        if (!rsp_fifo_empty && (stale_q == STALE_W'(0))) begin
          match          = 1'b1;
          rsp_fifo_rd_en = 1'b1;
          state_n        = ST_IDLE;
        end else if (cnt_q == CNT_W'(TIMEOUT - 1)) begin
          timeout = 1'b1;
          state_n = ST_IDLE;
        end
      end
      ST_DRAIN: begin
        if (!i_source_sleep_req) begin
          state_n = ST_IDLE;
        end else if (req_fifo_empty && (stale_q == STALE_W'(0))) begin
          state_n = ST_SLEEP;
        end
      end
      ST_SLEEP: begin
        if (!i_source_sleep_req) state_n = ST_IDLE;
      end
      default: state_n = ST_IDLE;
    endcase

    // A timeout owes one more late response; a discard settles one.
    unique case ({timeout, discard})
      2'b10:   stale_n = (stale_q == STALE_W'(3)) ? stale_q : stale_q + STALE_W'(1);
      2'b01:   stale_n = stale_q - STALE_W'(1);
      default: stale_n = stale_q;
    endcase
  end

  always_ff @(posedge i_clk_source) begin
    if (i_rst_source) begin
      state_q             <= ST_IDLE;
      cnt_q               <= '0;
      stale_q             <= '0;
      o_rd_valid          <= 1'b0;
      o_rd_data           <= '0;
      o_rd_err            <= 1'b0;
      o_source_sleep_ack  <= 1'b0;
      source_sleep_status <= 1'b0;
      reset_flag          <= 1'b1;
    end else begin
      state_q    <= state_n;
      cnt_q      <= cnt_n;
      stale_q    <= stale_n;
      o_rd_valid <= match || timeout;
      if (match) begin
        o_rd_err  <= i_rsp_packet[DATA_WIDTH];
        o_rd_data <= i_rsp_packet[DATA_WIDTH-1:0];
      end else if (timeout) begin
        o_rd_err  <= 1'b1;
        o_rd_data <= '0;
      end
      // Sleep outputs track the state being entered so they release on the exit edge.
      o_source_sleep_ack  <= (state_n == ST_SLEEP);
      source_sleep_status <= (state_n == ST_SLEEP);
      reset_flag          <= !((state_n == ST_SLEEP) && sink_sleep_status);
    end
  end

endmodule

// File: tb/tb_source_controller.sv
// Self-checking bench for source_controller: scoreboard queues hold expected
// request packets and read completions, compared when the DUT produces them.
module tb_source_controller;

  localparam int unsigned AW = 32;
  localparam int unsigned DW = 32;
  localparam int unsigned TO = 8;
  localparam int unsigned PW = AW + DW + 2;

  logic          clk;
  logic          rst;
  logic          valid;
  logic          rd0_wr1;
  logic [AW-1:0] addr;
  logic [DW-1:0] wr_data;
  logic          ready;
  logic          rd_valid;
  logic [DW-1:0] rd_data;
  logic          rd_err;
  logic          req_full;
  logic          req_empty;
  logic          wr_en;
  logic [PW-1:0] packet;
  logic          rsp_empty;
  logic [DW:0]   rsp_packet;
  logic          rsp_rd_en;
  logic          sleep_req;
  logic          sleep_ack;
  logic          src_status;
  logic          sink_status;
  logic          reset_flag;

  int errors = 0;
  int checks = 0;

  logic [PW-1:0] wr_q[$];
  logic [DW:0]   rd_q[$];
  logic [PW-1:0] exp_pkt;
  logic [DW:0]   exp_rsp;

  source_controller #(
    .ADDR_WIDTH(AW), .DATA_WIDTH(DW), .TIMEOUT(TO), .CNT_W(4)
  ) dut (
    .i_clk_source       (clk),
    .i_rst_source       (rst),
    .i_valid            (valid),
    .i_rd0_wr1          (rd0_wr1),
    .i_addr             (addr),
    .i_wr_data          (wr_data),
    .o_ready            (ready),
    .o_rd_valid         (rd_valid),
    .o_rd_data          (rd_data),
    .o_rd_err           (rd_err),
    .req_fifo_full      (req_full),
    .req_fifo_empty     (req_empty),
    .req_fifo_wr_en     (wr_en),
    .o_packet           (packet),
    .rsp_fifo_empty     (rsp_empty),
    .i_rsp_packet       (rsp_packet),
    .rsp_fifo_rd_en     (rsp_rd_en),
    .i_source_sleep_req (sleep_req),
    .o_source_sleep_ack (sleep_ack),
    .source_sleep_status(src_status),
    .sink_sleep_status  (sink_status),
    .reset_flag         (reset_flag)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Drive a read request at a negedge and check the combinational push.
  task automatic issue_read(input logic [AW-1:0] a);
    @(negedge clk);
    valid = 1'b1; rd0_wr1 = 1'b0; addr = a; wr_data = $urandom;
    wr_q.push_back({1'b0, 1'b1, a, 32'h0});
    #1;
    checks++;
    if (wr_en !== 1'b1) begin errors++; $display("FAIL rd_push: got %b expected 1", wr_en); end
    if (wr_en === 1'b1 && wr_q.size() > 0) begin
      exp_pkt = wr_q.pop_front();
      checks++;
      if (packet !== exp_pkt) begin errors++; $display("FAIL rd_packet: got %h expected %h", packet, exp_pkt); end
    end
    @(negedge clk);
    valid = 1'b0;
  endtask

  // Observe a completion at this negedge and compare against the scoreboard head.
  task automatic expect_completion(input string name);
    checks++;
    if (rd_valid !== 1'b1) begin
      errors++; $display("FAIL %s_valid: got %b expected 1", name, rd_valid);
    end else if (rd_q.size() == 0) begin
      errors++; $display("FAIL %s_unexpected: got completion expected none", name);
    end else begin
      exp_rsp = rd_q.pop_front();
      checks++;
      if ({rd_err, rd_data} !== exp_rsp) begin
        errors++; $display("FAIL %s_data: got %h expected %h", name, {rd_err, rd_data}, exp_rsp);
      end
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    checks++;
    if ({rd_valid, rd_data, rd_err} !== {1'b0, 32'h0, 1'b0}) begin
      errors++; $display("FAIL reset_rd: got %h expected 0", {rd_valid, rd_data, rd_err});
    end
    checks++;
    if ({sleep_ack, src_status, reset_flag} !== 3'b001) begin
      errors++; $display("FAIL reset_sleep: got %b expected 001", {sleep_ack, src_status, reset_flag});
    end
    rst = 1'b0;
    #1;
    checks++;
    if ({ready, wr_en, rsp_rd_en} !== 3'b100) begin
      errors++; $display("FAIL reset_comb: got %b expected 100", {ready, wr_en, rsp_rd_en});
    end
  endtask

  task automatic test_posted_writes();
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      valid = 1'b1; rd0_wr1 = 1'b1;
      addr = AW'(32'h10 + 4 * i); wr_data = DW'(32'hA0 + i);
      wr_q.push_back({1'b1, 1'b1, addr, wr_data});
      #1;
      checks++;
      if (wr_en !== 1'b1) begin errors++; $display("FAIL wr_push[%0d]: got %b expected 1", i, wr_en); end
      if (wr_en === 1'b1 && wr_q.size() > 0) begin
        exp_pkt = wr_q.pop_front();
        checks++;
        if (packet !== exp_pkt) begin errors++; $display("FAIL wr_packet[%0d]: got %h expected %h", i, packet, exp_pkt); end
      end
    end
    @(negedge clk);
    req_full = 1'b1; addr = 32'h20; wr_data = 32'hA4;
    #1;
    checks++;
    if ({ready, wr_en} !== 2'b00) begin errors++; $display("FAIL wr_full: got %b expected 00", {ready, wr_en}); end
    @(negedge clk);
    valid = 1'b0; req_full = 1'b0;
  endtask

  task automatic test_read_round_trip();
    issue_read(32'h40);
    for (int k = 1; k < 5; k++) begin
      checks++;
      if ({ready, rsp_rd_en, rd_valid} !== 3'b000) begin
        errors++; $display("FAIL rt_wait[%0d]: got %b expected 000", k, {ready, rsp_rd_en, rd_valid});
      end
      @(negedge clk);
    end
    rsp_empty = 1'b0; rsp_packet = {1'b0, 32'h12345678};
    rd_q.push_back({1'b0, 32'h12345678});
    #1;
    checks++;
    if (rsp_rd_en !== 1'b1) begin errors++; $display("FAIL rt_pop: got %b expected 1", rsp_rd_en); end
    @(negedge clk);
    rsp_empty = 1'b1;
    expect_completion("rt");
    checks++;
    if (ready !== 1'b1) begin errors++; $display("FAIL rt_ready: got %b expected 1", ready); end
    @(negedge clk);
    checks++;
    if (rd_valid !== 1'b0) begin errors++; $display("FAIL rt_pulse_width: got %b expected 0", rd_valid); end
  endtask

  // Read with no response: the error pulse lands TO cycles after the accept edge.
  task automatic timeout_read(input logic [AW-1:0] a, input string name);
    issue_read(a);
    rd_q.push_back({1'b1, 32'h0});
    for (int k = 1; k <= int'(TO); k++) begin
      @(negedge clk);
      if (k < int'(TO)) begin
        checks++;
        if (rd_valid !== 1'b0) begin errors++; $display("FAIL %s_early[%0d]: got %b expected 0", name, k, rd_valid); end
      end else begin
        expect_completion(name);
        checks++;
        if (ready !== 1'b1) begin errors++; $display("FAIL %s_ready: got %b expected 1", name, ready); end
      end
    end
  endtask

  task automatic test_watchdog();
    timeout_read(32'h80, "wd");
    rsp_empty = 1'b0; rsp_packet = {1'b0, 32'h0000BEEF};
    #1;
    checks++;
    if (rsp_rd_en !== 1'b1) begin errors++; $display("FAIL wd_discard_pop: got %b expected 1", rsp_rd_en); end
    @(negedge clk);
    rsp_empty = 1'b1;
    checks++;
    if (rd_valid !== 1'b0) begin errors++; $display("FAIL wd_discard_silent: got %b expected 0", rd_valid); end
    issue_read(32'h84);
    rsp_empty = 1'b0; rsp_packet = {1'b0, 32'h0000CAFE};
    rd_q.push_back({1'b0, 32'h0000CAFE});
    @(negedge clk);
    rsp_empty = 1'b1;
    expect_completion("wd_next");
  endtask

  // A response arriving in the last watchdog cycle wins over the timeout.
  task automatic test_timeout_boundary();
    issue_read(32'h88);
    repeat (TO - 1) @(negedge clk);
    checks++;
    if (rd_valid !== 1'b0) begin errors++; $display("FAIL tb_early: got %b expected 0", rd_valid); end
    rsp_empty = 1'b0; rsp_packet = {1'b1, 32'h5555AAAA};
    rd_q.push_back({1'b1, 32'h5555AAAA});
    #1;
    checks++;
    if (rsp_rd_en !== 1'b1) begin errors++; $display("FAIL tb_pop: got %b expected 1", rsp_rd_en); end
    @(negedge clk);
    rsp_empty = 1'b1;
    expect_completion("tb_edge");
    issue_read(32'h8C);
    rsp_empty = 1'b0; rsp_packet = {1'b0, 32'h00000F0F};
    rd_q.push_back({1'b0, 32'h00000F0F});
    @(negedge clk);
    rsp_empty = 1'b1;
    expect_completion("tb_no_stale");
  endtask

  task automatic test_sleep();
    req_empty = 1'b0;
    for (int i = 0; i < 2; i++) begin
      @(negedge clk);
      valid = 1'b1; rd0_wr1 = 1'b1;
      addr = AW'(32'h20 + 4 * i); wr_data = DW'(32'hB0 + i);
      wr_q.push_back({1'b1, 1'b1, addr, wr_data});
      #1;
      if (wr_en === 1'b1 && wr_q.size() > 0) begin
        exp_pkt = wr_q.pop_front();
        checks++;
        if (packet !== exp_pkt) begin errors++; $display("FAIL sl_packet[%0d]: got %h expected %h", i, packet, exp_pkt); end
      end
    end
    @(negedge clk);
    addr = 32'h30; sleep_req = 1'b1;
    #1;
    checks++;
    if ({ready, wr_en} !== 2'b00) begin errors++; $display("FAIL sl_wins: got %b expected 00", {ready, wr_en}); end
    @(negedge clk);
    valid = 1'b0;
    for (int k = 0; k < 3; k++) begin
      checks++;
      if ({ready, sleep_ack, src_status} !== 3'b000) begin
        errors++; $display("FAIL sl_drain[%0d]: got %b expected 000", k, {ready, sleep_ack, src_status});
      end
      @(negedge clk);
    end
    req_empty = 1'b1;
    @(negedge clk);
    checks++;
    if ({sleep_ack, src_status, reset_flag} !== 3'b111) begin
      errors++; $display("FAIL sl_enter: got %b expected 111", {sleep_ack, src_status, reset_flag});
    end
    sink_status = 1'b1;
    @(negedge clk);
    checks++;
    if (reset_flag !== 1'b0) begin errors++; $display("FAIL sl_reset_flag: got %b expected 0", reset_flag); end
    sleep_req = 1'b0;
    @(negedge clk);
    checks++;
    if ({ready, sleep_ack, src_status, reset_flag} !== 4'b1001) begin
      errors++; $display("FAIL sl_exit: got %b expected 1001", {ready, sleep_ack, src_status, reset_flag});
    end
    sink_status = 1'b0;
    req_empty = 1'b0;
    sleep_req = 1'b1;
    @(negedge clk);
    checks++;
    if (ready !== 1'b0) begin errors++; $display("FAIL sl_abort_drain: got %b expected 0", ready); end
    sleep_req = 1'b0;
    @(negedge clk);
    checks++;
    if ({ready, src_status} !== 2'b10) begin errors++; $display("FAIL sl_abort_idle: got %b expected 10", {ready, src_status}); end
    req_empty = 1'b1;
  endtask

  task automatic test_reset_mid_read();
    timeout_read(32'h90, "rm_prep");
    issue_read(32'h94);
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    for (int k = 0; k < int'(TO) + 2; k++) begin
      checks++;
      if (rd_valid !== 1'b0) begin errors++; $display("FAIL rm_no_pulse[%0d]: got %b expected 0", k, rd_valid); end
      @(negedge clk);
    end
    checks++;
    if (ready !== 1'b1) begin errors++; $display("FAIL rm_ready: got %b expected 1", ready); end
    issue_read(32'h98);
    rsp_empty = 1'b0; rsp_packet = {1'b0, 32'h00000077};
    rd_q.push_back({1'b0, 32'h00000077});
    #1;
    checks++;
    if (rsp_rd_en !== 1'b1) begin errors++; $display("FAIL rm_pop: got %b expected 1", rsp_rd_en); end
    @(negedge clk);
    rsp_empty = 1'b1;
    expect_completion("rm_after");
  endtask

  initial begin
    rst = 1'b1; valid = 1'b0; rd0_wr1 = 1'b0; addr = '0; wr_data = '0;
    req_full = 1'b0; req_empty = 1'b1; rsp_empty = 1'b1; rsp_packet = '0;
    sleep_req = 1'b0; sink_status = 1'b0;
    test_reset();
    test_posted_writes();
    test_read_round_trip();
    test_watchdog();
    test_timeout_boundary();
    test_sleep();
    test_reset_mid_read();
    checks++;
    if (wr_q.size() != 0 || rd_q.size() != 0) begin
      errors++; $display("FAIL scoreboard_drain: got %0d/%0d left expected 0/0", wr_q.size(), rd_q.size());
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL global_timeout: got no finish expected finish");
    $fatal(1, "bench time limit");
  end

endmodule
